// File: rtl/tri_bus_arbiter_if.sv
// Bundles the request/enable signals between bus masters and the tri-state arbiter.
// Latency: none, wires only.
// Backpressure: req is held by a master until it no longer wants the bus.
interface tri_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int IDW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] en;
    logic                   grant_valid;
    logic [IDW-1:0]         grant_id;
    logic                   preempt;

    // Requesters drive req and observe the grant.
    modport master (
        output req,
        input  en,
        input  grant_valid,
        input  grant_id,
        input  preempt
    );

    // The arbiter observes req and owns the enables.
    modport slave (
        input  req,
        output en,
        output grant_valid,
        output grant_id,
        output preempt
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of the tri-state enables of a shared inout bus, with turnaround gaps.
// Latency: req sampled at an edge drives en high from that same edge (one registered stage).
// Backpressure: tenure bounded to MAX_HOLD cycles only while another master is waiting.
module tri_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int MAX_HOLD    = 8,
    parameter int TURNAROUND  = 1
) (
    input  logic                clk,
    input  logic                rst,
    tri_bus_arbiter_if.slave    bus
);
    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam int TW  = $clog2(TURNAROUND + 1);

    localparam logic [HW-1:0]  HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0]  TURN_MAX  = TW'(TURNAROUND);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [TW-1:0]          turn_q, turn_d;
    logic [IDW-1:0]         last_q, last_d;
    logic [NUM_MASTERS-1:0] en_q, en_d;
    logic                   gv_q, gv_d;
    logic [IDW-1:0]         id_q, id_d;
    logic                   pre_q, pre_d;

    logic [IDW-1:0]         pick;
    logic                   any_req;
    logic                   owner_req;
    logic                   others_req;
    logic                   rel_drop;
    logic                   rel_hold;
    logic                   do_arb;

    // First requester found scanning upward from the one after the previous owner,
    // so the previous owner is always considered last.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] r,
        input logic [IDW-1:0]         l
    );
        logic [IDW-1:0] w;
        logic [IDW-1:0] idx;
        logic           found;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = IDW'((int'(l) + i) % NUM_MASTERS);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign pick       = rr_pick(bus.req, last_q);
    assign any_req    = |bus.req;
    // en_q is one-hot on the owner while in GRANT, so it doubles as the owner mask.
    assign owner_req  = |(bus.req & en_q);
    assign others_req = |(bus.req & ~en_q);
    assign rel_drop   = !owner_req;
    assign rel_hold   = (hold_q == HOLD_MAX) && others_req;

    // Next-state and registered-output values; arbitration shared by IDLE and end of TURN.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        last_d  = last_q;
        en_d    = en_q;
        gv_d    = gv_q;
        id_d    = id_q;
        pre_d   = 1'b0;
        do_arb  = 1'b0;

        case (state_q)
            IDLE: begin
                do_arb = 1'b1;
            end
            GRANT: begin
                if (rel_drop || rel_hold) begin
                    // Release always goes through TURN, even if someone is already waiting.
                    en_d    = '0;
                    gv_d    = 1'b0;
                    id_d    = '0;
                    hold_d  = '0;
                    turn_d  = TW'(1);
                    pre_d   = rel_hold;
                    state_d = TURN;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            TURN: begin
                if (turn_q == TURN_MAX) begin
                    do_arb = 1'b1;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                en_d    = '0;
                gv_d    = 1'b0;
                id_d    = '0;
                state_d = IDLE;
            end
        endcase

        if (do_arb) begin
            if (any_req) begin
                en_d    = NUM_MASTERS'(1) << pick;
                gv_d    = 1'b1;
                id_d    = pick;
                last_d  = pick;
                hold_d  = HW'(1);
                turn_d  = '0;
                state_d = GRANT;
            end else begin
                turn_d  = '0;
                state_d = IDLE;
            end
        end
    end

    // State and output registers; reset drops the enables immediately with no turnaround.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            turn_q  <= '0;
            last_q  <= LAST_INIT;
            en_q    <= '0;
            gv_q    <= 1'b0;
            id_q    <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            last_q  <= last_d;
            en_q    <= en_d;
            gv_q    <= gv_d;
            id_q    <= id_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.en          = en_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_id    = id_q;
    assign bus.preempt     = pre_q;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed scenarios then random requests against a reference model.
// Latency: model advances at each rising edge, outputs compared 1 time unit later.
// Backpressure: requests held/dropped randomly to exercise drop, preempt and reset paths.
module tb_tri_bus_arbiter;
    localparam int N  = 3;
    localparam int MH = 4;
    localparam int TA = 1;

    logic clk = 1'b0;
    logic rst;

    // Free-running clock.
    always #5 clk = ~clk;

    tri_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    tri_bus_arbiter #(
        .NUM_MASTERS(N),
        .MAX_HOLD   (MH),
        .TURNAROUND (TA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the bus, how long, and how many idle cycles remain.
    int     m_owner;
    int     m_held;
    int     m_gap;
    int     m_last;
    bit     m_pre;
    logic [N-1:0] prev_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rs);
        bit others;
        int c;
        if (rs) begin
            m_owner = -1;
            m_held  = 0;
            m_gap   = 0;
            m_last  = N - 1;
            m_pre   = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner >= 0) begin
                others = 1'b0;
                for (int j = 0; j < N; j++)
                    if (j != m_owner && r[j]) others = 1'b1;
                if (!r[m_owner] || (m_held >= MH && others)) begin
                    m_pre   = (m_held >= MH) && others;
                    m_owner = -1;
                    m_gap   = TA;
                end else if (m_held < MH) begin
                    m_held++;
                end
            end else begin
                if (m_gap > 0) m_gap--;
                if (m_gap == 0) begin
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (m_owner < 0 && r[c]) begin
                            m_owner = c;
                            m_held  = 1;
                            m_last  = c;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_en;
        int idx;
        exp_en = (m_owner < 0) ? '0 : N'(1 << m_owner);
        check("en", bus.en, exp_en);
        check("grant_valid", bus.grant_valid, (m_owner >= 0));
        check("grant_id", bus.grant_id, (m_owner < 0) ? 0 : m_owner);
        check("preempt", bus.preempt, m_pre);
        check("inv_onehot", ($countones(bus.en) <= 1), 1);
        check("inv_gv", bus.grant_valid, |bus.en);
        if (bus.en != '0) begin
            idx = 0;
            for (int j = 0; j < N; j++) if (bus.en[j]) idx = j;
            check("inv_id", bus.grant_id, idx);
        end
        check("inv_no_switch", (prev_en != '0 && bus.en != '0 && prev_en != bus.en), 0);
        prev_en = bus.en;
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic rs);
        bus.req = r;
        rst     = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [N-1:0] exp_seq;
        logic [N-1:0] rr;
        int pos;

        bus.req = '0;
        rst     = 1'b1;
        prev_en = '0;
        m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_pre = 1'b0;

        // Reset and quiet idle.
        cycle(3'b000, 1'b1);
        cycle(3'b000, 1'b1);
        check("rst_en", bus.en, 3'b000);
        for (int i = 0; i < 10; i++) cycle(3'b000, 1'b0);
        check("idle_id", bus.grant_id, 0);

        // Single tenure then drop.
        cycle(3'b001, 1'b0);
        check("single_en", bus.en, 3'b001);
        cycle(3'b001, 1'b0);
        cycle(3'b001, 1'b0);
        cycle(3'b000, 1'b0);
        check("single_drop", bus.en, 3'b000);
        cycle(3'b000, 1'b0);
        cycle(3'b000, 1'b0);
        check("single_idle", bus.en, 3'b000);

        // All requesting from reset: fixed rotation with preempt on each gap.
        cycle(3'b111, 1'b1);
        cycle(3'b111, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cycle(3'b111, 1'b0);
            pos     = i % 5;
            exp_seq = (pos == 4) ? 3'b000 : N'(1 << ((i / 5) % 3));
            check("rr_seq_en", bus.en, exp_seq);
            check("rr_seq_pre", bus.preempt, (pos == 4));
        end

        // Sole continuous requester never loses the bus, then yields to master 0.
        cycle(3'b000, 1'b1);
        cycle(3'b000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(3'b010, 1'b0);
            check("sole_en", bus.en, 3'b010);
            check("sole_pre", bus.preempt, 0);
        end
        cycle(3'b011, 1'b0);
        check("sole_release", bus.en, 3'b000);
        check("sole_release_pre", bus.preempt, 1);
        cycle(3'b011, 1'b0);
        check("sole_next", bus.en, 3'b001);

        // Release and new request in the same cycle.
        cycle(3'b000, 1'b1);
        cycle(3'b000, 1'b1);
        cycle(3'b001, 1'b0);
        cycle(3'b001, 1'b0);
        cycle(3'b100, 1'b0);
        check("swap_gap", bus.en, 3'b000);
        cycle(3'b100, 1'b0);
        check("swap_en", bus.en, 3'b100);
        check("swap_id", bus.grant_id, 2);

        // Reset mid-tenure restores the pointer.
        cycle(3'b000, 1'b1);
        cycle(3'b000, 1'b1);
        cycle(3'b010, 1'b0);
        cycle(3'b010, 1'b0);
        check("midrst_pre", bus.en, 3'b010);
        cycle(3'b011, 1'b1);
        check("midrst_en", bus.en, 3'b000);
        cycle(3'b011, 1'b0);
        check("midrst_ptr", bus.en, 3'b001);

        // Random requests with sticky levels and rare resets.
        rr = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rr = N'($urandom_range(0, 7));
            cycle(rr, ($urandom_range(0, 79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
Round-robin arbiter that owns the tri-state enables of up to NUM_MASTERS tri_state_bus drivers sharing one inout data bus.
- Guarantees at most one enable is high in any cycle.
- Inserts TURNAROUND all-released cycles between owners so no two drivers overlap.
- Bounds each tenure to MAX_HOLD cycles while others wait.
- Sits beside the bus drivers; its en outputs connect directly to each driver's tri_state_en.

Parameters:
NUM_MASTERS, 3, number of requesters/drivers on the bus (2..16)
MAX_HOLD, 8, max consecutive grant cycles while another requester is pending (>=1)
TURNAROUND, 1, all-enables-low cycles between two tenures (>=1)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_MASTERS  per-master bus request, level-sensitive, held while master wants the bus
en  output  NUM_MASTERS  registered one-hot-or-zero tri-state enables, one per driver
grant_valid  output  1  registered; 1 when any en bit is high
grant_id  output  IDW  registered index of current owner, IDW = max(1, $clog2(NUM_MASTERS)); 0 when idle
preempt  output  1  registered one-cycle pulse when a tenure ends by MAX_HOLD expiry

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: en=0, grant_valid=0, grant_id=0, preempt=0, state=IDLE, hold_cnt=0, rr pointer last=NUM_MASTERS-1 (master 0 has highest priority first).
- rst high mid-tenure: en drops to 0 at that edge, with no turnaround counted; all state returns to reset values.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0 at edge t, pick the first set bit searching last+1, last+2, … modulo NUM_MASTERS.
  - At edge t: en[winner]=1, grant_id=winner, grant_valid=1, last=winner, hold_cnt=1, go to GRANT.
  - Latency req-sampled to en-high is one edge.
- GRANT, owner o:
  - Release at edge t if either:
    (a) req[o]=0, or
    (b) hold_cnt==MAX_HOLD and (req & ~(1<<o))!=0.
  - On release: en=0, grant_valid=0, grant_id=0, go to TURN with turn_cnt=1. preempt=1 for that one cycle only in case (b).
  - Otherwise en stays. hold_cnt increments, saturating at MAX_HOLD.
  - A sole requester never releases. A sole requester never gets a turnaround cycle.
- TURN:
  - en=0.
  - When turn_cnt==TURNAROUND, arbitrate exactly as in IDLE at that edge. With a winner go to GRANT; otherwise go to IDLE.
  - Else turn_cnt++.
  - Net result: exactly TURNAROUND cycles with en=0 between tenures.
  - Requests arriving or dropping during TURN are honoured only at arbitration edges.
- Round-robin fairness: the previous owner is searched last. With all requesting, grant order cycles 0,1,2,0,…
- Invariants, checked by the bench every cycle:
  - popcount(en)<=1.
  - grant_valid == |en.
  - grant_id == index of the en bit.
  - en never switches directly from one nonzero value to a different nonzero value.
- req bits for masters already granted are don't-care except for the owner.
- Simultaneous release and new req in the same cycle: release wins; the new master waits for TURN.
- Counters sized $clog2(MAX_HOLD+1) and $clog2(TURNAROUND+1); no wrap beyond saturation.

Test Plan:
All scenarios use NUM_MASTERS=3, MAX_HOLD=4, TURNAROUND=1, rst=1 for 2 cycles.
1. Reset: after reset, en=000, grant_valid=0, grant_id=0, preempt=0; with req=000 held 10 cycles, outputs stay constant.
2. Single tenure: req=001 seen at edge 3 → en=001, grant_id=0 from edge 3. Drop req at edge 6 → en=000 from edge 6, exactly 1 turnaround cycle, then IDLE with en=000.
3. All-request fairness: req=111 held continuously from reset. Expected en sequence: 001 ×4, 000, 010 ×4, 000, 100 ×4, 000, 001 …; preempt pulses on each of the 000 cycles.
4. Sole continuous requester: req=010 held 20 cycles → en=010 for all 20 cycles, no gap, preempt never 1. Adding req[0] at cycle 20: en stays 010 until hold_cnt==4 is reached (already saturated, so release at the next edge), then 000 for 1 cycle, then 001.
5. Release plus new request in one edge: owner 0 drops req while req[2] rises in the same cycle → en=000 for 1 cycle, then en=100, grant_id=2.
6. Reset mid-operation: rst=1 during en=010 → en=000 at that edge. After rst=0 with req=011, master 0 is granted first (pointer reset).
